qerv_bufreg_seq: RTL and testbench

Phase sequencer for the serial buffer register in the W-bit-per-cycle core. It accepts one instruction at a time and drives the buffer register's control strobes through four phases:

- an init phase that accumulates rs1+imm;
- an optional data-bus wait (memory ops);
- an optional coarse shift phase (shift ops);
- an execute phase that streams the result out.

It sits between the decoder/issue logic and the buffer register, and owns the data-bus request strobe.

---
 rtl/qerv_bufreg_seq.sv | 164 ++++++++++++++++
 tb/tb_qerv_bufreg_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/qerv_bufreg_seq.sv
// Phase sequencer for the serial buffer register: INIT -> [MEMWAIT | SHIFT] -> RUN.
// Define QERV_MISALIGN_TRAP_EN to trap misaligned word/half accesses at the end of INIT.
module qerv_bufreg_seq #(
  parameter int W  = 4,
  parameter int LB = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_mem_op,
  input  logic          i_shift_op,
  input  logic          i_mem_word,
  input  logic          i_mem_half,
  input  logic [4:0]    i_shamt,
  input  logic [1:0]    i_lsb,
  input  logic          i_dbus_ack,
  output logic          o_ready,
  output logic          o_en,
  output logic          o_init,
  output logic          o_cnt0,
  output logic          o_cnt1,
  output logic [LB:0]   o_shift_counter_lsb,
  output logic          o_dbus_cyc,
  output logic          o_done,
  output logic          o_trap
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MEMWAIT, S_SHIFT, S_RUN, S_TRAP
  } state_e;

  localparam logic [4:0] STEP = 5'(W);
  localparam logic [4:0] LAST = 5'(32 - W);

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       mem_op_q, mem_op_d;
  logic       shift_op_q, shift_op_d;
  logic [4:0] shamt_q, shamt_d;
  logic [4:0] shamt_hi;
  logic       misaligned;

  // Whole-W shift steps; the remaining sub-word part goes to o_shift_counter_lsb.
  assign shamt_hi = shamt_q >> LB;

`ifdef QERV_MISALIGN_TRAP_EN
  logic word_q, word_d;
  logic half_q, half_d;

  assign misaligned = (word_q & (|i_lsb)) | (half_q & i_lsb[0]);

  always_comb begin
    word_d = word_q;
    half_d = half_q;
    if (state_q == S_IDLE && i_start) begin
      word_d = i_mem_word;
      half_d = i_mem_half;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      word_q <= 1'b0;
      half_q <= 1'b0;
    end else begin
      word_q <= word_d;
      half_q <= half_d;
    end
  end

  assign o_trap = (state_q == S_TRAP);
`else
  logic unused_inputs;
  assign unused_inputs = ^{i_lsb, i_mem_word, i_mem_half};
  assign misaligned    = 1'b0;
  assign o_trap        = 1'b0;
`endif

  // NOTE: every signal gets its hold value before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_op_d   = mem_op_q;
    shift_op_d = shift_op_q;
    shamt_d    = shamt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          mem_op_d   = i_mem_op;
          shift_op_d = i_shift_op & ~i_mem_op;
          shamt_d    = i_shamt;
          cnt_d      = 5'd0;
          state_d    = S_INIT;
        end
      end
      S_INIT: begin
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) begin
          cnt_d = 5'd0;
          if (mem_op_q)
            state_d = misaligned ? S_TRAP : S_MEMWAIT;
          else if (shift_op_q && shamt_hi != 5'd0)
            state_d = S_SHIFT;
          else
            state_d = S_RUN;
        end
      end
      S_MEMWAIT: begin
        if (i_dbus_ack) state_d = S_RUN;
      end
      S_SHIFT: begin
        // cnt counts single cycles here and is back at 0 when RUN begins.
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == shamt_hi - 5'd1) begin
          cnt_d   = 5'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) begin
          cnt_d   = 5'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      mem_op_q   <= 1'b0;
      shift_op_q <= 1'b0;
      shamt_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_op_q   <= mem_op_d;
      shift_op_q <= shift_op_d;
      shamt_q    <= shamt_d;
    end
  end

  assign o_ready    = (state_q == S_IDLE);
  assign o_en       = (state_q == S_INIT) || (state_q == S_SHIFT) || (state_q == S_RUN);
  assign o_init     = (state_q == S_INIT);
  assign o_cnt0     = ((state_q == S_INIT) || (state_q == S_RUN)) && (cnt_q == 5'd0);
  assign o_cnt1     = ((state_q == S_INIT) || (state_q == S_RUN)) && (cnt_q == STEP);
  assign o_dbus_cyc = (state_q == S_MEMWAIT);
  assign o_done     = (state_q == S_RUN) && (cnt_q == LAST);

  generate
    if (LB == 0) begin : g_no_sub
      assign o_shift_counter_lsb = '0;
    end else begin : g_sub
      assign o_shift_counter_lsb =
        (shift_op_q && (state_q == S_SHIFT || state_q == S_RUN)) ? {1'b0, shamt_q[LB-1:0]} : '0;
    end
  endgenerate

endmodule

// File: tb/tb_qerv_bufreg_seq.sv
// Directed bench for qerv_bufreg_seq: a W=4 instance for all phases plus a W=1 instance for beat count.
// Cycle c is the interval after edge c-1 of an issue sampled at edge 0; outputs are sampled at negedges.
module tb_qerv_bufreg_seq;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_mem_op = 1'b0;
  logic       i_shift_op = 1'b0;
  logic       i_mem_word = 1'b0;
  logic       i_mem_half = 1'b0;
  logic [4:0] i_shamt = 5'd0;
  logic [1:0] i_lsb = 2'd0;
  logic       i_dbus_ack = 1'b0;

  logic       ready4, en4, init4, cnt0_4, cnt1_4, cyc4, done4, trap4;
  logic [2:0] sh4;
  logic       ready1, en1, init1, cnt0_1, cnt1_1, cyc1, done1, trap1;
  logic [0:0] sh1;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  qerv_bufreg_seq #(.W(4)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mem_op(i_mem_op),
    .i_shift_op(i_shift_op), .i_mem_word(i_mem_word), .i_mem_half(i_mem_half),
    .i_shamt(i_shamt), .i_lsb(i_lsb), .i_dbus_ack(i_dbus_ack),
    .o_ready(ready4), .o_en(en4), .o_init(init4), .o_cnt0(cnt0_4), .o_cnt1(cnt1_4),
    .o_shift_counter_lsb(sh4), .o_dbus_cyc(cyc4), .o_done(done4), .o_trap(trap4)
  );

  qerv_bufreg_seq #(.W(1)) dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mem_op(i_mem_op),
    .i_shift_op(i_shift_op), .i_mem_word(i_mem_word), .i_mem_half(i_mem_half),
    .i_shamt(i_shamt), .i_lsb(i_lsb), .i_dbus_ack(i_dbus_ack),
    .o_ready(ready1), .o_en(en1), .o_init(init1), .o_cnt0(cnt0_1), .o_cnt1(cnt1_1),
    .o_shift_counter_lsb(sh1), .o_dbus_cyc(cyc1), .o_done(done1), .o_trap(trap1)
  );

  // Packed as {ready, en, init, cnt0, cnt1, dbus_cyc, done, trap, shift_lsb}.
  function automatic logic [10:0] obs4();
    return {ready4, en4, init4, cnt0_4, cnt1_4, cyc4, done4, trap4, sh4};
  endfunction

  function automatic logic [8:0] obs1();
    return {ready1, en1, init1, cnt0_1, cnt1_1, cyc1, done1, trap1, sh1};
  endfunction

  // Leaves the bench at the negedge inside cycle 1.
  task automatic issue(input logic mem, input logic shift, input logic word,
                       input logic half, input logic [4:0] shamt);
    @(negedge i_clk);
    i_start = 1'b1; i_mem_op = mem; i_shift_op = shift;
    i_mem_word = word; i_mem_half = half; i_shamt = shamt;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] exp4;
    logic [8:0]  exp1;
    exp4 = 11'b100_0000_0000;
    exp1 = 9'b1_0000_0000;
    i_rst_n = 1'b0; i_start = 1'b1; i_mem_op = 1'b1; i_dbus_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      if (c == 3) begin i_rst_n = 1'b1; i_start = 1'b0; i_mem_op = 1'b0; i_dbus_ack = 1'b0; end
      total++;
      if (obs4() !== exp4) begin
        bad++; $display("FAIL reset4 c=%0d got=%b exp=%b", c, obs4(), exp4);
      end
      total++;
      if (obs1() !== exp1) begin
        bad++; $display("FAIL reset1 c=%0d got=%b exp=%b", c, obs1(), exp1);
      end
    end
  endtask

  task automatic test_w1_plain();
    logic [8:0] exp;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int c = 1; c <= 65; c++) begin
      exp = {c >= 65, c <= 64, c <= 32, (c == 1 || c == 33), (c == 2 || c == 34),
             1'b0, c == 64, 1'b0, 1'b0};
      total++;
      if (obs1() !== exp) begin
        bad++; $display("FAIL w1_plain c=%0d got=%b exp=%b", c, obs1(), exp);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_plain_ignore_start();
    logic [10:0] exp;
    issue(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int c = 1; c <= 18; c++) begin
      exp = {c >= 17, c <= 16, c <= 8, (c == 1 || c == 9), (c == 2 || c == 10),
             1'b0, c == 16, 1'b0, 3'd0};
      total++;
      if (obs4() !== exp) begin
        bad++; $display("FAIL plain c=%0d got=%b exp=%b", c, obs4(), exp);
      end
      i_start  = (c == 3 || c == 16);
      i_mem_op = i_start;
      @(negedge i_clk);
    end
    i_start = 1'b0; i_mem_op = 1'b0;
  endtask

  task automatic test_mem_wait();
    logic [10:0] exp;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    for (int c = 1; c <= 21; c++) begin
      exp = {c >= 21, (c <= 8 || (c >= 13 && c <= 20)), c <= 8,
             (c == 1 || c == 13), (c == 2 || c == 14), (c >= 9 && c <= 12),
             c == 20, 1'b0, 3'd0};
      total++;
      if (obs4() !== exp) begin
        bad++; $display("FAIL mem_wait c=%0d got=%b exp=%b", c, obs4(), exp);
      end
      i_dbus_ack = (c == 12);
      @(negedge i_clk);
    end
    i_dbus_ack = 1'b0;
  endtask

  task automatic test_misalign_first_ack();
    logic [10:0] exp;
    i_lsb = 2'd2;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    for (int c = 1; c <= 18; c++) begin
`ifdef QERV_MISALIGN_TRAP_EN
      exp = {c >= 10, c <= 8, c <= 8, c == 1, c == 2, 1'b0, 1'b0, c == 9, 3'd0};
`else
      exp = {c >= 18, (c <= 8 || (c >= 10 && c <= 17)), c <= 8,
             (c == 1 || c == 10), (c == 2 || c == 11), c == 9, c == 17, 1'b0, 3'd0};
`endif
      total++;
      if (obs4() !== exp) begin
        bad++; $display("FAIL misalign c=%0d got=%b exp=%b", c, obs4(), exp);
      end
      i_dbus_ack = (c == 9);
      @(negedge i_clk);
    end
    i_dbus_ack = 1'b0; i_lsb = 2'd0;
  endtask

  task automatic test_shift();
    logic [10:0] exp;
    issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd13);
    for (int c = 1; c <= 20; c++) begin
      exp = {c >= 20, c <= 19, c <= 8, (c == 1 || c == 12), (c == 2 || c == 13),
             1'b0, c == 19, 1'b0, (c >= 9 && c <= 19) ? 3'd1 : 3'd0};
      total++;
      if (obs4() !== exp) begin
        bad++; $display("FAIL shift13 c=%0d got=%b exp=%b", c, obs4(), exp);
      end
      @(negedge i_clk);
    end
    issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd2);
    for (int c = 1; c <= 17; c++) begin
      exp = {c >= 17, c <= 16, c <= 8, (c == 1 || c == 9), (c == 2 || c == 10),
             1'b0, c == 16, 1'b0, (c >= 9 && c <= 16) ? 3'd2 : 3'd0};
      total++;
      if (obs4() !== exp) begin
        bad++; $display("FAIL shift2 c=%0d got=%b exp=%b", c, obs4(), exp);
      end
      @(negedge i_clk);
    end
    i_shift_op = 1'b0; i_shamt = 5'd0;
  endtask

  task automatic test_reset_in_memwait();
    logic [10:0] exp;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    for (int c = 1; c <= 15; c++) begin
      if (c <= 10)
        exp = {1'b0, c <= 8, c <= 8, c == 1, c == 2, c >= 9, 1'b0, 1'b0, 3'd0};
      else
        exp = 11'b100_0000_0000;
      total++;
      if (obs4() !== exp) begin
        bad++; $display("FAIL reset_memwait c=%0d got=%b exp=%b", c, obs4(), exp);
      end
      i_rst_n    = (c != 10);
      i_dbus_ack = (c == 12);
      @(negedge i_clk);
    end
    i_rst_n = 1'b1; i_dbus_ack = 1'b0; i_mem_op = 1'b0; i_mem_word = 1'b0;
  endtask

  initial begin
    test_reset();
    test_w1_plain();
    test_plain_ignore_start();
    test_mem_wait();
    test_misalign_first_ack();
    test_shift();
    test_reset_in_memwait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
